// File: rtl/serial_add_ctrl.sv
// Multi-cycle WIDTH-bit adder that reuses one 2-bit adder slice, LSB slice first, with start/done handshake.
// Optional signed-overflow flag output enabled by defining OVERFLOW_FLAG_EN.

module adder2bit (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  input  logic       cin_i,
  output logic [1:0] sum_o,
  output logic       cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {2'b00, cin_i};
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);
  localparam int NSLICE = WIDTH / 2;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  acc_q;

  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [1:0]        slice_sum;
  logic              slice_cout;
  logic [WIDTH-1:0]  sum_d;
  logic              accept;
  logic              last_slice;

  assign accept     = start && (state_q != S_RUN);
  assign last_slice = (idx_q == IDXW'(NSLICE - 1));
  assign a_sh       = a_q >> {idx_q, 1'b0};
  assign b_sh       = b_q >> {idx_q, 1'b0};

  adder2bit u_slice (
    .a_i    (a_sh[1:0]),
    .b_i    (b_sh[1:0]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // Accumulator with the current slice result merged in; on the last slice this is the final sum.
  assign sum_d = (acc_q & ~(WIDTH'(2'b11) << {idx_q, 1'b0}))
               | (WIDTH'(slice_sum) << {idx_q, 1'b0});

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
    if (state_q == S_RUN) begin
      acc_q <= sum_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= S_RUN;
            idx_q   <= '0;
            carry_q <= cin;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          carry_q <= slice_cout;
          idx_q   <= idx_q + 1'b1;
          if (last_slice) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= sum_d;
            cout_q  <= slice_cout;
`ifdef OVERFLOW_FLAG_EN
            ovf     <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
